// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, branch flushes,
// whole-pipe freeze on data-memory wait with timeout to HALT, and a saturating stall counter.
module pipeline_hazard_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 15,
   parameter int unsigned TO_W        = 4,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             IDEX_MemRead,
   input  logic [4:0]       IDEX_RD,
   input  logic [4:0]       IFID_RS1,
   input  logic [4:0]       IFID_RS2,
   input  logic             Branch_Taken,
   input  logic             Mem_Req,
   input  logic             Mem_Ready,
   output logic             PC_Write,
   output logic             IFID_Write,
   output logic             IDEX_Bubble,
   output logic             IFID_Flush,
   output logic             IDEX_Flush,
   output logic             Pipe_Freeze,
   output logic             Mem_Timeout,
   output logic [1:0]       State,
   output logic [CNT_W-1:0] Stall_Count
);

   typedef enum logic [1:0] {
      StRun     = 2'b00,
      StMemWait = 2'b01,
      StHalt    = 2'b10
   } state_e;

   localparam logic [TO_W-1:0]  TimeoutVal = TO_W'(MEM_TIMEOUT);
   localparam logic [CNT_W-1:0] CntMax     = '1;

   state_e           state_q, state_d;
   logic [TO_W-1:0]  wait_cnt_q, wait_cnt_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic             timeout_q, timeout_d;
   logic             lu_hazard, miss, run_eval;

   assign lu_hazard = IDEX_MemRead && (IDEX_RD != 5'd0) &&
                      ((IDEX_RD == IFID_RS1) || (IDEX_RD == IFID_RS2));
   assign miss      = Mem_Req && !Mem_Ready;

   always_comb begin
      PC_Write    = 1'b0;
      IFID_Write  = 1'b0;
      IDEX_Bubble = 1'b0;
      IFID_Flush  = 1'b0;
      IDEX_Flush  = 1'b0;
      Pipe_Freeze = 1'b0;
      run_eval    = 1'b0;
      state_d     = state_q;
      wait_cnt_d  = wait_cnt_q;
      timeout_d   = timeout_q;
      stall_cnt_d = stall_cnt_q;

      unique case (state_q)
         StRun: begin
            if (miss) begin
               Pipe_Freeze = 1'b1;
               wait_cnt_d  = TO_W'(1);
               if (wait_cnt_d == TimeoutVal) begin
                  state_d   = StHalt;
                  timeout_d = 1'b1;
               end else begin
                  state_d = StMemWait;
               end
            end else begin
               run_eval = 1'b1;
            end
         end
         StMemWait: begin
            if (!Mem_Ready) begin
               Pipe_Freeze = 1'b1;
               // wait_cnt_q < MEM_TIMEOUT here, so the increment cannot overflow
               wait_cnt_d  = wait_cnt_q + TO_W'(1);
               if (wait_cnt_d == TimeoutVal) begin
                  state_d   = StHalt;
                  timeout_d = 1'b1;
               end
            end else begin
               run_eval   = 1'b1;
               state_d    = StRun;
               wait_cnt_d = '0;
            end
         end
         StHalt: begin
            Pipe_Freeze = 1'b1;
         end
         default: begin
            state_d = StRun;
         end
      endcase

      // Branch wins over load-use: the flushed ID instruction no longer needs the load result
      if (run_eval) begin
         if (Branch_Taken) begin
            IFID_Flush = 1'b1;
            IDEX_Flush = 1'b1;
            PC_Write   = 1'b1;
            IFID_Write = 1'b1;
         end else if (lu_hazard) begin
            IDEX_Bubble = 1'b1;
         end else begin
            PC_Write   = 1'b1;
            IFID_Write = 1'b1;
         end
      end

      if (reset) begin
         PC_Write    = 1'b0;
         IFID_Write  = 1'b0;
         IDEX_Bubble = 1'b0;
         IFID_Flush  = 1'b0;
         IDEX_Flush  = 1'b0;
         Pipe_Freeze = 1'b0;
      end

      if ((Pipe_Freeze || IDEX_Bubble) && (stall_cnt_q != CntMax)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StRun;
         wait_cnt_q  <= '0;
         stall_cnt_q <= '0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         stall_cnt_q <= stall_cnt_d;
         timeout_q   <= timeout_d;
      end
   end

   assign State       = state_q;
   assign Mem_Timeout = timeout_q;
   assign Stall_Count = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: a behavioural model feeds a scoreboard queue,
// with a second narrow-counter instance for saturation.
module tb_pipeline_hazard_ctrl;

   localparam int MemTimeout = 15;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset, IDEX_MemRead, Branch_Taken, Mem_Req, Mem_Ready;
   logic [4:0] IDEX_RD, IFID_RS1, IFID_RS2;

   logic        PC_Write, IFID_Write, IDEX_Bubble, IFID_Flush, IDEX_Flush, Pipe_Freeze, Mem_Timeout;
   logic [1:0]  State;
   logic [15:0] Stall_Count;

   logic        pc_w_b, ifid_w_b, bubble_b, ifid_fl_b, idex_fl_b, freeze_b, to_b;
   logic [1:0]  state_b;
   logic [3:0]  Stall_Count_b;

   pipeline_hazard_ctrl #(.MEM_TIMEOUT(MemTimeout), .TO_W(4), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .IDEX_MemRead(IDEX_MemRead), .IDEX_RD(IDEX_RD),
      .IFID_RS1(IFID_RS1), .IFID_RS2(IFID_RS2), .Branch_Taken(Branch_Taken),
      .Mem_Req(Mem_Req), .Mem_Ready(Mem_Ready), .PC_Write(PC_Write), .IFID_Write(IFID_Write),
      .IDEX_Bubble(IDEX_Bubble), .IFID_Flush(IFID_Flush), .IDEX_Flush(IDEX_Flush),
      .Pipe_Freeze(Pipe_Freeze), .Mem_Timeout(Mem_Timeout), .State(State),
      .Stall_Count(Stall_Count)
   );

   pipeline_hazard_ctrl #(.MEM_TIMEOUT(MemTimeout), .TO_W(4), .CNT_W(4)) dut_narrow (
      .clk(clk), .reset(reset), .IDEX_MemRead(IDEX_MemRead), .IDEX_RD(IDEX_RD),
      .IFID_RS1(IFID_RS1), .IFID_RS2(IFID_RS2), .Branch_Taken(Branch_Taken),
      .Mem_Req(Mem_Req), .Mem_Ready(Mem_Ready), .PC_Write(pc_w_b), .IFID_Write(ifid_w_b),
      .IDEX_Bubble(bubble_b), .IFID_Flush(ifid_fl_b), .IDEX_Flush(idex_fl_b),
      .Pipe_Freeze(freeze_b), .Mem_Timeout(to_b), .State(state_b),
      .Stall_Count(Stall_Count_b)
   );

   typedef struct packed {
      logic        pc_w;
      logic        ifid_w;
      logic        bubble;
      logic        ifid_fl;
      logic        idex_fl;
      logic        freeze;
      logic        to;
      logic [1:0]  st;
      logic [15:0] cnt;
      logic [3:0]  cnt4;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   int   m_state = 0;
   int   m_wait  = 0;
   int   m_cnt   = 0;
   int   m_cnt4  = 0;
   logic m_to    = 1'b0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic exp_t model_out();
      exp_t e;
      logic lu, miss, run;
      e      = '0;
      e.st   = 2'(m_state);
      e.to   = m_to;
      e.cnt  = 16'(m_cnt);
      e.cnt4 = 4'(m_cnt4);
      lu   = IDEX_MemRead && IDEX_RD != 0 && (IDEX_RD == IFID_RS1 || IDEX_RD == IFID_RS2);
      miss = Mem_Req && !Mem_Ready;
      run  = 1'b0;
      if (!reset) begin
         if (m_state == 2) e.freeze = 1'b1;
         else if (m_state == 1 && !Mem_Ready) e.freeze = 1'b1;
         else if (m_state == 0 && miss) e.freeze = 1'b1;
         else run = 1'b1;
      end
      if (run) begin
         if (Branch_Taken) begin
            e.ifid_fl = 1'b1; e.idex_fl = 1'b1; e.pc_w = 1'b1; e.ifid_w = 1'b1;
         end else if (lu) begin
            e.bubble = 1'b1;
         end else begin
            e.pc_w = 1'b1; e.ifid_w = 1'b1;
         end
      end
      return e;
   endfunction

   task automatic model_update(input exp_t e);
      if (reset) begin
         m_state = 0; m_wait = 0; m_cnt = 0; m_cnt4 = 0; m_to = 1'b0;
      end else begin
         if (e.freeze || e.bubble) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt4 < 15) m_cnt4++;
         end
         if (m_state == 0) begin
            if (Mem_Req && !Mem_Ready) begin
               m_wait = 1;
               if (m_wait == MemTimeout) begin m_state = 2; m_to = 1'b1; end
               else m_state = 1;
            end
         end else if (m_state == 1) begin
            if (!Mem_Ready) begin
               m_wait++;
               if (m_wait == MemTimeout) begin m_state = 2; m_to = 1'b1; end
            end else begin
               m_state = 0; m_wait = 0;
            end
         end
      end
   endtask

   task automatic cycle(input logic rst, input logic mr, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic br, input logic req, input logic rdy);
      exp_t e, got;
      @(negedge clk);
      reset = rst; IDEX_MemRead = mr; IDEX_RD = rd; IFID_RS1 = rs1; IFID_RS2 = rs2;
      Branch_Taken = br; Mem_Req = req; Mem_Ready = rdy;
      #1;
      exp_q.push_back(model_out());
      #1;
      e = exp_q.pop_front();
      got = '{PC_Write, IFID_Write, IDEX_Bubble, IFID_Flush, IDEX_Flush, Pipe_Freeze,
              Mem_Timeout, State, Stall_Count, Stall_Count_b};
      if (got !== e) begin
         check_val("pc_write",    PC_Write,      e.pc_w);
         check_val("ifid_write",  IFID_Write,    e.ifid_w);
         check_val("idex_bubble", IDEX_Bubble,   e.bubble);
         check_val("ifid_flush",  IFID_Flush,    e.ifid_fl);
         check_val("idex_flush",  IDEX_Flush,    e.idex_fl);
         check_val("pipe_freeze", Pipe_Freeze,   e.freeze);
         check_val("mem_timeout", Mem_Timeout,   e.to);
         check_val("state",       State,         e.st);
         check_val("stall_count", Stall_Count,   e.cnt);
         check_val("stall_cnt4",  Stall_Count_b, e.cnt4);
      end else begin
         check_val("cycle_outputs", got, e);
      end
      @(posedge clk);
      model_update(e);
      #1;
   endtask

   task automatic idle();
      cycle(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      cycle(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      reset = 1'b1; IDEX_MemRead = 1'b0; IDEX_RD = '0; IFID_RS1 = '0; IFID_RS2 = '0;
      Branch_Taken = 1'b0; Mem_Req = 1'b0; Mem_Ready = 1'b0;

      // reset with hazard inputs active: outputs must stay forced low
      cycle(1'b1, 1'b1, 5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0);
      do_reset();
      check_val("rst_state", State, 2'b00);
      check_val("rst_cnt", Stall_Count, 16'd0);

      // load-use on RS2
      cycle(1'b0, 1'b1, 5'd5, 5'd1, 5'd5, 1'b0, 1'b0, 1'b0);
      check_val("t1_cnt", Stall_Count, 16'd1);
      idle();
      // RD=0 never stalls
      cycle(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      check_val("t2_cnt", Stall_Count, 16'd1);
      // branch masks load-use
      cycle(1'b0, 1'b1, 5'd7, 5'd7, 5'd2, 1'b1, 1'b0, 1'b0);
      check_val("t3_cnt", Stall_Count, 16'd1);

      // three-cycle memory wait
      do_reset();
      repeat (3) cycle(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
      check_val("t4_wait_state", State, 2'b01);
      cycle(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
      check_val("t4_state", State, 2'b00);
      check_val("t4_cnt", Stall_Count, 16'd3);

      // load-use held across a freeze re-presents on release
      repeat (2) cycle(1'b0, 1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 1'b1, 1'b0);
      cycle(1'b0, 1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 1'b1, 1'b1);
      idle();

      // timeout to HALT after 15 freeze cycles, then reset clears everything
      do_reset();
      repeat (15) cycle(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
      check_val("t5_state", State, 2'b10);
      check_val("t5_timeout", Mem_Timeout, 1'b1);
      check_val("t5_cnt", Stall_Count, 16'd15);
      cycle(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1);
      do_reset();
      check_val("t5_rst_state", State, 2'b00);
      check_val("t5_rst_timeout", Mem_Timeout, 1'b0);
      check_val("t5_rst_cnt", Stall_Count, 16'd0);

      // narrow counter saturates
      do_reset();
      for (int i = 0; i < 30; i++)
         cycle(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, (i % 5) == 4);
      check_val("t6_cnt4", Stall_Count_b, 4'd15);
      check_val("t6_cnt16", Stall_Count, 16'd24);

      // random traffic, then a slow-memory stretch that reaches HALT
      for (int i = 0; i < 300; i++)
         cycle($urandom_range(0, 99) < 3, $urandom_range(0, 1) == 1,
               5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               $urandom_range(0, 3) == 0, $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 6);
      for (int i = 0; i < 80; i++)
         cycle(i == 70, $urandom_range(0, 1) == 1,
               5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               $urandom_range(0, 3) == 0, 1'b1, $urandom_range(0, 19) == 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
